// File: rtl/display_scanner.sv
// Time-multiplexed 7-segment scanner with frame-boundary (tear-free) value updates.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scanner #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [3:0]            nibble,
  output logic                  seg_enable,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_done
);

  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned W  = 4 * DIGITS;
  localparam logic [PW-1:0] PreLast = PW'(DIV - 1);
  localparam logic [IW-1:0] IdxLast = IW'(DIGITS - 1);

  logic [PW-1:0]     prescaler_q, prescaler_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [W-1:0]      active_q, active_d;
  logic [W-1:0]      pending_q, pending_d;
  logic              pend_v_q, pend_v_d;
  logic [3:0]        nibble_q, nibble_d;
  logic              seg_enable_q, seg_enable_d;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic              frame_done_q;
  logic              tick, wrap;
`ifdef LEADING_ZERO_BLANK_EN
  logic              zero_above;
  logic              blank;
`endif

  always_comb begin
    tick        = (prescaler_q == PreLast);
    wrap        = tick && (idx_q == IdxLast);
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end

    pending_d = load ? value : pending_q;

    pend_v_d = pend_v_q;
    if (wrap) begin
      pend_v_d = 1'b0;
    end else if (load) begin
      pend_v_d = 1'b1;
    end

    // A load landing on the wrap tick bypasses pending and goes straight to active.
    active_d = active_q;
    if (wrap) begin
      if (load) begin
        active_d = value;
      end else if (pend_v_q) begin
        active_d = pending_q;
      end
    end
  end

  // Outputs are derived from next-state so they change on the same edge as idx.
  always_comb begin
    nibble_d     = 4'h0;
    anode_d      = '1;
    seg_enable_d = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        nibble_d   = active_d[4*k +: 4];
        anode_d[k] = 1'b0;
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    zero_above = 1'b1;
    blank      = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (active_d[4*k +: 4] == 4'h0);
      if ((idx_d == IW'(k)) && zero_above) begin
        blank = 1'b1;
      end
    end
    if (blank) begin
      nibble_d     = 4'h0;
      anode_d      = '1;
      seg_enable_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_q  <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_v_q     <= 1'b0;
      nibble_q     <= 4'h0;
      seg_enable_q <= 1'b0;
      anode_q      <= {{(DIGITS-1){1'b1}}, 1'b0};
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
      nibble_q     <= nibble_d;
      seg_enable_q <= seg_enable_d;
      anode_q      <= anode_d;
      frame_done_q <= wrap;
    end
  end

  assign nibble     = nibble_q;
  assign seg_enable = seg_enable_q;
  assign anode      = anode_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner (DIGITS=4, DIV=4) using a cycle-time reference model.
// Honours LEADING_ZERO_BLANK_EN when the same macro is defined for the build.
module tb_display_scanner;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int F      = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  nibble;
  logic        seg_enable;
  logic [3:0]  anode;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  // Model: t = edges since reset release; digit = (t/DIV)%DIGITS.
  int          t = 0;
  logic [15:0] m_act = '0;
  logic [15:0] m_pend = '0;
  logic        m_pv = 1'b0;

  display_scanner #(
    .DIGITS(DIGITS),
    .DIV   (DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .value     (value),
    .nibble    (nibble),
    .seg_enable(seg_enable),
    .anode     (anode),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_outputs();
    int          d;
    logic [3:0]  e_nib;
    logic [3:0]  e_an;
    logic        e_se;
    logic        e_fd;
    logic [15:0] upper;
    d     = (t / DIV) % DIGITS;
    upper = m_act >> (4 * d);
    e_nib = upper[3:0];
    e_an  = 4'b1111 ^ (4'b0001 << d);
    e_se  = 1'b0;
    e_fd  = (t > 0) && (t % F == 0);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && upper == 16'h0) begin
      e_nib = 4'h0;
      e_an  = 4'b1111;
      e_se  = 1'b1;
    end
`endif
    checks++;
    assert (nibble === e_nib) else begin
      failures++;
      $error("FAIL nibble t=%0d got=%h exp=%h", t, nibble, e_nib);
    end
    checks++;
    assert (anode === e_an) else begin
      failures++;
      $error("FAIL anode t=%0d got=%b exp=%b", t, anode, e_an);
    end
    checks++;
    assert (seg_enable === e_se) else begin
      failures++;
      $error("FAIL seg_enable t=%0d got=%b exp=%b", t, seg_enable, e_se);
    end
    checks++;
    assert (frame_done === e_fd) else begin
      failures++;
      $error("FAIL frame_done t=%0d got=%b exp=%b", t, frame_done, e_fd);
    end
  endtask

  task automatic cyc(input logic rst, input logic ld, input logic [15:0] v);
    reset = rst;
    load  = ld;
    value = v;
    @(posedge clk);
    if (rst) begin
      t      = 0;
      m_act  = '0;
      m_pend = '0;
      m_pv   = 1'b0;
    end else begin
      t++;
      if (t % F == 0) begin
        if (ld) m_act = v;
        else if (m_pv) m_act = m_pend;
        m_pv = 1'b0;
      end else if (ld) begin
        m_pend = v;
        m_pv   = 1'b1;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic adv_to(input int ph);
    int n;
    n = 0;
    while ((t % F) != ph && n < 2 * F) begin
      cyc(1'b0, 1'b0, 16'h0);
      n++;
    end
  endtask

  initial begin
    int n;
    logic [15:0] rv;
    // Reset held 3 cycles.
    repeat (3) cyc(1'b1, 1'b0, 16'h0);
    adv_to(2);
    cyc(1'b0, 1'b1, 16'h1234);
    // Bounded wait for frame_done.
    n = 0;
    while (frame_done !== 1'b1 && n < 2 * F) begin
      cyc(1'b0, 1'b0, 16'h0);
      n++;
    end
    checks++;
    assert (frame_done === 1'b1 && m_act == 16'h1234) else begin
      failures++;
      $error("FAIL wait_frame_done got=%b exp=1", frame_done);
    end
    // Full frame of 1234, then tear-free update while digit 2 is lit.
    adv_to(9);
    cyc(1'b0, 1'b1, 16'hABCD);
    adv_to(0);
    // Boundary collision: load on the wrap-tick cycle.
    adv_to(F - 1);
    cyc(1'b0, 1'b1, 16'h00F0);
    adv_to(3);
    cyc(1'b0, 1'b1, 16'h1111);
    adv_to(6);
    cyc(1'b0, 1'b1, 16'h2222);
    adv_to(0);
    adv_to(F - 1);
    // Reset mid-frame with a load pending.
    adv_to(5);
    cyc(1'b0, 1'b1, 16'h3333);
    repeat (3) cyc(1'b0, 1'b0, 16'h0);
    repeat (2) cyc(1'b1, 1'b0, 16'h0);
    repeat (2 * F + 3) cyc(1'b0, 1'b0, 16'h0);
    // Leading-zero patterns.
    adv_to(F - 1);
    cyc(1'b0, 1'b1, 16'h0050);
    adv_to(F - 1);
    cyc(1'b0, 1'b1, 16'h0000);
    adv_to(0);
    adv_to(F - 1);
    // Randomized loads, some with zero upper digits.
    for (int i = 0; i < 400; i++) begin
      rv = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rv = rv & 16'h000F;
        1: rv = rv & 16'h00FF;
        2: rv = rv & 16'h0FFF;
        default: ;
      endcase
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0), rv);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Time-multiplexes a DIGITS-wide packed hex value onto a shared 7-segment decoder, one digit per refresh slot.
- Sits directly upstream of the 7-segment decoder. It drives the decoder's 4-bit nibble input and its active-low enable.
- Also drives the active-low digit anodes.
- New values are loaded through a one-cycle strobe and take effect only at a frame boundary, so a partially updated (torn) frame is never shown.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- DIV, 50000, clock cycles per digit slot (>=2).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures value into the pending register.
- value  in  4*DIGITS  packed nibbles; digit 0 = value[3:0] (least significant).
- nibble  out  4  hex code for the current digit, to the decoder input.
- seg_enable  out  1  decoder enable, active low (0 = decode, 1 = blank).
- anode  out  DIGITS  digit select, active low, at most one bit low.
- frame_done  out  1  one-cycle pulse when the digit index wraps to 0.

Behaviour:
- Reset (synchronous, dominates all other inputs):
  - prescaler=0, idx=0, active=0, pending=0, pend_v=0.
  - nibble=4'h0, seg_enable=0, anode=~1 (digit 0 low), frame_done=0.
- Prescaler:
  - counts 0..DIV-1, then wraps to 0.
  - tick is asserted while prescaler==DIV-1.
- Digit index:
  - on a tick, idx increments; DIGITS-1 wraps to 0.
  - each digit is lit for exactly DIV cycles; a full frame is DIGITS*DIV cycles.
- Outputs are registered and update on the same edge that idx changes, computed from the next idx and next active value:
  - nibble = active[4*idx+3:4*idx].
  - anode = all ones with bit idx cleared.
  - seg_enable = 0.
- Load:
  - when load=1, pending <= value and pend_v <= 1.
  - a later load before the frame boundary overwrites pending (last value wins).
- Frame boundary (the tick where idx wraps DIGITS-1 -> 0):
  - if pend_v, active <= pending and pend_v <= 0.
  - digit 0 of the new frame already shows the new active value.
  - frame_done=1 for exactly that one cycle.
- load on the boundary-tick cycle: value bypasses pending, goes straight to active, and pend_v ends at 0.
- load with no boundary: active is unchanged and the display keeps showing the old value.
- Reset mid-frame: abandons the frame and discards pending; scanning restarts at digit 0 with value 0.
- No outputs are combinational from inputs; load never affects outputs before the next frame boundary.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: for digit k >= 1, if active nibbles k..DIGITS-1 are all 4'h0, that slot is blanked.
  - Blanked slot: seg_enable=1, anode=all ones, nibble=4'h0; slot timing is unchanged.
  - Digit 0 is never blanked.
- Not defined: every digit is always displayed, including leading zeros.

Test Plan (DIGITS=4, DIV=4):
- Reset: reset held 3 cycles, then released -> anode=4'b1110, nibble=0, seg_enable=0; first idx change exactly 4 cycles after release.
- Scan order: load 16'h1234, wait for frame_done -> next frame shows nibble 4,3,2,1 with anode 1110,1101,1011,0111, each held 4 cycles; frame_done pulses once per 16 cycles.
- Tear-free update: load 16'hABCD while digit 2 is lit -> digits 2 and 3 keep showing the old value; the new value appears from digit 0 of the next frame.
- Boundary collision: load 16'h00F0 on the wrap-tick cycle -> digit 0 of the new frame shows 0, digit 1 shows F; pend_v=0 afterwards.
- Double load and reset: load 16'h1111 then 16'h2222 in the same frame -> only 2222 is shown. Then reset mid-frame with a load pending -> the display shows 0000 and the pending value never appears.
- With LEADING_ZERO_BLANK_EN, active=16'h0050:
  - digits 3 and 2: seg_enable=1, anode=4'b1111.
  - digit 1 shows 5; digit 0 shows 0.
  - active=0: only digit 0 is lit.
